multichannel_sample_fifo: RTL
=============================

// Module: multichannel_sample_fifo
// PURPOSE
//  Parametrised sample buffer between the I2S receiver and the S/PDIF transmitter, clocked once per audio frame.
//  Stores CHANNELS samples of WORDSIZE bits per entry.
//  Reports level, almost-full/almost-empty watermarks and sticky overflow/underflow flags to the system management unit.
//  Read-data timing is selectable: registered (1-cycle) or first-word-fall-through.
// PARAMETERS
//  WORDSIZE   32  bits per channel sample
//  CHANNELS   2   channels per entry (1..8); channel k occupies bits [k*WORDSIZE +: WORDSIZE]
//  DEPTH      16  entries; power of two, >= 2
//  AF_THRESH  12  almost_full asserted when level >= AF_THRESH
//  AE_THRESH  4   almost_empty asserted when level <= AE_THRESH
//  FWFT       0   0 = registered read data, 1 = first-word-fall-through
// PORTS
//  pin_i2s_fclk  in   1                    frame clock; all state updates on rising edge
//  rst           in   1                    synchronous, active-high reset
//  write_en      in   1                    write request
//  data_in       in   CHANNELS*WORDSIZE    entry to write
//  read_en       in   1                    read request
//  data_out      out  CHANNELS*WORDSIZE    read entry
//  clear_flags   in   1                    clears overflow/underflow
//  level         out  $clog2(DEPTH)+1      entries stored, 0..DEPTH
//  full          out  1                    level == DEPTH
//  empty         out  1                    level == 0
//  almost_full   out  1                    level >= AF_THRESH
//  almost_empty  out  1                    level <= AE_THRESH
//  overflow      out  1                    sticky: write lost
//  underflow     out  1                    sticky: read on empty
// BEHAVIOUR
//  - Reset (rst=1 at clock edge): read and write pointers = 0; level = 0; data_out = 0; overflow = 0; underflow = 0.
//    Reset has priority over every other input and aborts in-flight operations.
//    After reset: empty=1, full=0, almost_empty=1, almost_full=0.
//  - Pointers are $clog2(DEPTH)+1 bits wide, with an extra wrap bit.
//    - full: addresses equal and wrap bits differ.
//    - empty: pointers equal.
//    - Pointers wrap modulo 2*DEPTH; memory is addressed by the low bits.
//  - Read acceptance: rd_ok = read_en & ~empty.
//  - Write acceptance: wr_ok = write_en & (~full | rd_ok).
//    A write on a full FIFO succeeds if a read is accepted in the same cycle.
//  - Pointer and level update:
//    - rd_ok increments the read pointer; wr_ok increments the write pointer.
//    - level += wr_ok - rd_ok; unchanged when both are accepted.
//  - Simultaneous read and write on an empty FIFO: the read is rejected and flags underflow; the write is accepted.
//  - overflow: set on write_en & full & ~rd_ok. underflow: set on read_en & empty.
//    - Both hold until clear_flags or rst.
//    - If a set condition and clear_flags occur in the same cycle, set wins.
//  - FWFT=0: on rd_ok, data_out takes the head entry at the next edge (1-cycle latency). Otherwise data_out holds its value.
//  - FWFT=1: data_out = head entry combinationally whenever ~empty, and 0 when empty. rd_ok advances to the next entry.
//  - Status outputs full, empty, almost_*, level: combinational from registered pointers, so they are valid in the cycle after the update edge.
//  - Data integrity: entries are read in write order, all CHANNELS lanes together. No lane reordering or bit reversal happens here.
// TESTING
//  - Reset: hold rst 2 cycles with write_en=1 -> level=0, empty=1, data_out=0, overflow=0.
//  - Fill: 16 writes of {R=i+100, L=i} -> full=1 after the 16th; almost_full rises when level=12.
//    A 17th write sets overflow=1 and leaves level=16.
//  - Drain, FWFT=0: 16 reads -> data_out = {100,0}..{115,15}, each 1 cycle after its read.
//    A 17th read sets underflow=1; data_out holds {115,15}.
//  - Full with simultaneous rd+wr: level stays 16, no overflow, head advances; new entry appears last.
//  - Empty with simultaneous rd+wr: underflow=1, level=1.
//    FWFT=1: data_out equals the written entry in the next cycle.
//  - Wrap and clear: 40 interleaved writes/reads at level 3 -> data order preserved across pointer wrap.
//    clear_flags=1 with no error condition -> overflow and underflow both 0.

Source files
------------

// File: rtl/multichannel_sample_fifo.sv
`default_nettype none
// ============================================================================
// Module   : multichannel_sample_fifo
// Purpose  : Multi-channel audio sample FIFO between the I2S receiver and the
//            S/PDIF transmitter. One entry holds CHANNELS samples of WORDSIZE
//            bits. Provides level, watermarks and sticky overflow/underflow
//            flags. Read data is either registered or first-word-fall-through.
// Revision : 1.0 - initial release
// ============================================================================
module multichannel_sample_fifo #(
  parameter int WORDSIZE  = 32,
  parameter int CHANNELS  = 2,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = 12,
  parameter int AE_THRESH = 4,
  parameter int FWFT      = 0
) (
  input  logic                             pin_i2s_fclk,
  input  logic                             rst,
  input  logic                             write_en,
  input  logic [CHANNELS*WORDSIZE-1:0]     data_in,
  input  logic                             read_en,
  output logic [CHANNELS*WORDSIZE-1:0]     data_out,
  input  logic                             clear_flags,
  output logic [$clog2(DEPTH):0]           level,
  output logic                             full,
  output logic                             empty,
  output logic                             almost_full,
  output logic                             almost_empty,
  output logic                             overflow,
  output logic                             underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int DW = CHANNELS * WORDSIZE;

  localparam logic [PW-1:0] c_af_thresh = PW'(AF_THRESH);
  localparam logic [PW-1:0] c_ae_thresh = PW'(AE_THRESH);
  localparam logic [PW-1:0] c_ptr_one   = PW'(1);

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  // when the addresses coincide.
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [DW-1:0] r_mem [DEPTH];
  logic          r_overflow;
  logic          r_underflow;

  logic [AW-1:0] w_wr_addr;
  logic [AW-1:0] w_rd_addr;
  logic          w_full;
  logic          w_empty;
  logic          w_rd_ok;
  logic          w_wr_ok;
  logic          w_ovf_set;
  logic          w_udf_set;
  logic [PW-1:0] w_level;

  assign w_wr_addr = r_wr_ptr[AW-1:0];
  assign w_rd_addr = r_rd_ptr[AW-1:0];
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (w_wr_addr == w_rd_addr) && (r_wr_ptr[AW] != r_rd_ptr[AW]);

  // A write into a full FIFO is still taken when a read frees a slot in the
  // same frame; a read on an empty FIFO is never taken, even with a write.
  assign w_rd_ok   = read_en & ~w_empty;
  assign w_wr_ok   = write_en & (~w_full | w_rd_ok);
  assign w_ovf_set = write_en & w_full & ~w_rd_ok;
  assign w_udf_set = read_en & w_empty;

  // Pointer difference modulo 2*DEPTH is the occupancy, 0..DEPTH.
  assign w_level = r_wr_ptr - r_rd_ptr;

  assign level        = w_level;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (w_level >= c_af_thresh);
  assign almost_empty = (w_level <= c_ae_thresh);
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

  // Advance read/write pointers on accepted transfers.
  always_ff @(posedge pin_i2s_fclk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_rd_ok) r_rd_ptr <= r_rd_ptr + c_ptr_one;
    end
  end

  // Sample storage; contents need no reset since pointers gate visibility.
  always_ff @(posedge pin_i2s_fclk) begin
    if (!rst && w_wr_ok) r_mem[w_wr_addr] <= data_in;
  end

  // Sticky error flags; a new error in the clearing frame keeps the flag set.
  always_ff @(posedge pin_i2s_fclk) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_ovf_set)        r_overflow  <= 1'b1;
      else if (clear_flags) r_overflow  <= 1'b0;
      if (w_udf_set)        r_underflow <= 1'b1;
      else if (clear_flags) r_underflow <= 1'b0;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head entry is visible combinationally; zero while nothing is stored.
      always_comb begin
        data_out = '0;
        if (!w_empty) data_out = r_mem[w_rd_addr];
      end
    end else begin : g_registered
      logic [DW-1:0] r_dout;

      // Head entry is captured on an accepted read and held otherwise.
      always_ff @(posedge pin_i2s_fclk) begin
        if (rst)          r_dout <= '0;
        else if (w_rd_ok) r_dout <= r_mem[w_rd_addr];
      end

      assign data_out = r_dout;
    end
  endgenerate

endmodule
`default_nettype wire
